csm_arbiter: RTL
================

# csm_arbiter

Two-port arbiter and lock controller for the shared 4 x 8-bit register store used by processors A and B. Each port issues reads, writes, hold (exclusive lock) and release commands. The block owns the storage, resolves simultaneous accesses with a round-robin pointer, and enforces hold ownership. It reports every outcome to its port as a registered grant or error pulse.

## Interface
- DEPTH, 4: number of words; address width is log2(DEPTH) = 2.
- WIDTH, 8: data word width.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req, b_req  in  1  access request (read or write) for port A / B.
- a_we, b_we  in  1  write enable qualifying req (1 = write, 0 = read).
- a_addr, b_addr  in  2  word address.
- a_wdata, b_wdata  in  8  write data.
- a_hold, b_hold  in  1  request exclusive lock.
- a_rel, b_rel  in  1  release lock.
- a_gnt, b_gnt  out  1  one-cycle pulse: command accepted.
- a_rdata, b_rdata  out  8  read data; valid when gnt pulses after a read.
- a_err, b_err  out  1  one-cycle pulse: command rejected.
- a_owns, b_owns  out  1  level: port currently holds the lock.

## Operation
- Lock FSM states: FREE, A_LOCK, B_LOCK. Reset -> FREE.
- FREE + x_hold -> X_LOCK with x_gnt. If a_hold and b_hold arrive together, the round-robin pointer (rr) picks the winner. Winner gets gnt; loser gets err. rr then flips to favour the loser.
- X_LOCK + x_rel -> FREE with x_gnt. A rel from a non-owner, or in FREE: err, no state change.
- X_LOCK + x_hold from the owner: gnt, state unchanged (re-hold is idempotent).
- While X_LOCK, any req or hold from the other port: err, no memory effect, no state change.
- Per port per cycle, at most one of req/hold/rel may be asserted. Two or more together: err, nothing performed.
- Accesses (locked owner, or either port in FREE):
  - Both read: both granted, any addresses.
  - Read and write to different addresses: both granted.
  - Read and write to the same address: both granted. The read returns the old value and the write lands at the edge.
  - Both write to different addresses: both granted.
  - Both write to the same address: the rr winner is granted and writes. The loser gets neither gnt nor err (stall) and must keep req asserted. rr flips after every contested cycle.
- A hold and an access in the same cycle from different ports, in FREE: the access completes, the hold is granted, and the lock takes effect next cycle.
- rr reset value favours A.

## Timing
- Commands are sampled at the rising edge. gnt, err and rdata are registered and appear on the cycle after sampling (1-cycle latency). gnt and err are never both high on a port.
- Writes update storage at the sampling edge. A read of that address sampled on the next cycle returns the new data.
- rdata holds its last value when gnt is low. After reset, rdata is 0.
- x_owns reflects the FSM state: it rises the cycle after the granted hold and falls the cycle after the granted release.
- Reset values: all storage 0; FSM FREE; rr = A; gnt, err, owns, rdata all 0.
- Reset mid-lock or mid-stall: lock dropped, pending stalls discarded, storage cleared. Commands in the reset cycle are ignored with no gnt/err.

## Test plan
- A write addr 2 = 0xA5, then B read addr 2 -> a_gnt, then b_gnt with b_rdata = 0xA5.
- A hold, then B read addr 1 -> a_owns = 1, b_err pulse, b_gnt = 0, memory unchanged; A rel, then B read -> b_gnt.
- Both hold in the same cycle after reset -> a_gnt, b_err, a_owns. A rel, then both hold again -> b_gnt, a_err (rr flipped).
- Both write addr 3 (A = 0x00, B = 0xFF) with req held -> cycle 1 a_gnt only; cycle 2 b_gnt; final read addr 3 = 0xFF.
- A write addr 0 = 0x3C while B reads addr 0 in the same cycle -> b_rdata = 0x00 (old); next B read -> 0x3C.
- B rel in FREE -> b_err. a_req and a_hold together -> a_err. Reset while A_LOCK -> a_owns = 0 and all words read 0.

Source files
------------

// File: rtl/csm_arbiter.sv
// Two-port arbiter and lock controller for a small shared register store.
// Round-robin resolves contested holds and same-address writes; outcomes are registered pulses.
module csm_arbiter #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  input  logic             a_hold,
  input  logic             a_rel,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  input  logic             b_hold,
  input  logic             b_rel,
  output logic             a_gnt,
  output logic [WIDTH-1:0] a_rdata,
  output logic             a_err,
  output logic             a_owns,
  output logic             b_gnt,
  output logic [WIDTH-1:0] b_rdata,
  output logic             b_err,
  output logic             b_owns
);

  typedef enum logic [1:0] {FREE, A_LOCK, B_LOCK} lock_t;

  lock_t            state, state_n;
  logic             rr, rr_n;
  logic [WIDTH-1:0] mem [DEPTH];

  logic a_bad, b_bad, a_acc, b_acc, a_hld, b_hld, a_rl, b_rl;
  logic a_may, b_may;
  logic a_gnt_n, b_gnt_n, a_err_n, b_err_n;
  logic a_acc_gnt, b_acc_gnt;
  logic a_wr, b_wr, a_rd, b_rd;

  assign a_owns = (state == A_LOCK);
  assign b_owns = (state == B_LOCK);

  // A port raising more than one command in a cycle is rejected outright.
  assign a_bad = (a_req & a_hold) | (a_req & a_rel) | (a_hold & a_rel);
  assign b_bad = (b_req & b_hold) | (b_req & b_rel) | (b_hold & b_rel);
  assign a_acc = a_req & ~a_bad;
  assign b_acc = b_req & ~b_bad;
  assign a_hld = a_hold & ~a_bad;
  assign b_hld = b_hold & ~b_bad;
  assign a_rl  = a_rel & ~a_bad;
  assign b_rl  = b_rel & ~b_bad;
  assign a_may = (state == FREE) || (state == A_LOCK);
  assign b_may = (state == FREE) || (state == B_LOCK);

  always_comb begin
    state_n   = state;
    rr_n      = rr;
    a_gnt_n   = 1'b0;
    b_gnt_n   = 1'b0;
    a_err_n   = a_bad;
    b_err_n   = b_bad;
    a_acc_gnt = 1'b0;
    b_acc_gnt = 1'b0;

    if (a_hld && b_hld && state == FREE) begin
      if (!rr) begin
        a_gnt_n = 1'b1;
        b_err_n = 1'b1;
        state_n = A_LOCK;
      end else begin
        b_gnt_n = 1'b1;
        a_err_n = 1'b1;
        state_n = B_LOCK;
      end
      rr_n = ~rr;
    end else begin
      if (a_hld) begin
        if (a_may) begin
          a_gnt_n = 1'b1;
          state_n = A_LOCK;
        end else begin
          a_err_n = 1'b1;
        end
      end
      if (b_hld) begin
        if (b_may) begin
          b_gnt_n = 1'b1;
          state_n = B_LOCK;
        end else begin
          b_err_n = 1'b1;
        end
      end
    end

    // Only the owner may release; anything else is rejected without effect.
    if (a_rl) begin
      if (state == A_LOCK) begin
        a_gnt_n = 1'b1;
        state_n = FREE;
      end else begin
        a_err_n = 1'b1;
      end
    end
    if (b_rl) begin
      if (state == B_LOCK) begin
        b_gnt_n = 1'b1;
        state_n = FREE;
      end else begin
        b_err_n = 1'b1;
      end
    end

    if (a_acc && !a_may) a_err_n = 1'b1;
    if (b_acc && !b_may) b_err_n = 1'b1;

    // Same-address double write: rr winner proceeds, loser stalls silently.
    if (a_acc && a_may && b_acc && b_may) begin
      if (a_we && b_we && a_addr == b_addr) begin
        a_acc_gnt = ~rr;
        b_acc_gnt = rr;
        rr_n      = ~rr;
      end else begin
        a_acc_gnt = 1'b1;
        b_acc_gnt = 1'b1;
      end
    end else begin
      a_acc_gnt = a_acc && a_may;
      b_acc_gnt = b_acc && b_may;
    end

    a_gnt_n = a_gnt_n | a_acc_gnt;
    b_gnt_n = b_gnt_n | b_acc_gnt;
  end

  assign a_wr = a_acc_gnt & a_we;
  assign b_wr = b_acc_gnt & b_we;
  assign a_rd = a_acc_gnt & ~a_we;
  assign b_rd = b_acc_gnt & ~b_we;

  // Reads sample the pre-edge contents, so a same-cycle write is not visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FREE;
      rr      <= 1'b0;
      a_gnt   <= 1'b0;
      b_gnt   <= 1'b0;
      a_err   <= 1'b0;
      b_err   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      rr    <= rr_n;
      a_gnt <= a_gnt_n;
      b_gnt <= b_gnt_n;
      a_err <= a_err_n;
      b_err <= b_err_n;
      if (a_rd) a_rdata <= mem[a_addr];
      if (b_rd) b_rdata <= mem[b_addr];
      if (a_wr) mem[a_addr] <= a_wdata;
      if (b_wr) mem[b_addr] <= b_wdata;
    end
  end

endmodule
